// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT helpers: bit-reversal and frame-position constants used by the
// R22SDF stages and by the bit-reversed-to-natural reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int MAX_NLOG2 = 16;

  localparam logic [MAX_NLOG2-1:0] FRAME_FIRST = '0;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low nbits of pos; higher bits of the result are zero.
  function automatic logic [MAX_NLOG2-1:0] bitrev(input logic [MAX_NLOG2-1:0] pos,
                                                  input int nbits);
    logic [MAX_NLOG2-1:0] src;
    logic [MAX_NLOG2-1:0] res;
    src = pos;
    res = '0;
    for (int i = 0; i < MAX_NLOG2; i++) begin
      if (i < nbits) begin
        res = {res[MAX_NLOG2-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_NLOG2-1:0] frame_last(input int nbits);
    return (MAX_NLOG2'(1) << nbits) - 1'b1;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram_sdp.sv
// Simple dual-port RAM: one write port and one registered read port with
// read enable; the read register holds its value while re_i is low.
module ram_sdp #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_3x_i,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset; stale words are never read because the
  // bank full flags gate every read.
  always_ff @(posedge clk_3x_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT frames into one bank and
// drains the other bank in natural order with a ready/valid output register.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = 1024,
  parameter int NLOG2      = 10
) (
  input  logic                         clk_3x_i,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [NLOG2-1:0]             ctr_i,
  input  logic signed [DATA_WIDTH-1:0] z_re_i,
  input  logic signed [DATA_WIDTH-1:0] z_im_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [NLOG2-1:0]             idx_o,
  output logic signed [DATA_WIDTH-1:0] re_o,
  output logic signed [DATA_WIDTH-1:0] im_o,
  output logic                         overflow_o
);

  localparam logic [NLOG2-1:0] CTR_FIRST = NLOG2'(FRAME_FIRST);
  localparam logic [NLOG2-1:0] CTR_LAST  = NLOG2'(frame_last(NLOG2));
  localparam int               WORD_W    = 2 * DATA_WIDTH;

  logic             wr_bank_q, wr_bank_d;
  logic             accept_q, accept_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       full_q, full_d;
  rd_state_e        state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [NLOG2-1:0] rd_addr_q, rd_addr_d;
  logic             valid_q, valid_d;
  logic [NLOG2-1:0] idx_q, idx_d;

  logic             frame_start, start_ok, wr_en, wr_last;
  logic             rd_en, rd_last;
  logic [NLOG2:0]   wr_addr;
  logic [WORD_W-1:0] rd_word;

  // Write side: a frame is admitted or dropped as a whole at ctr_i == 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    frame_start = valid_i && (ctr_i == CTR_FIRST);
    start_ok    = frame_start && !full_q[wr_bank_q];
    wr_en       = start_ok || (valid_i && accept_q && !frame_start);
    wr_last     = wr_en && (ctr_i == CTR_LAST);
    wr_addr     = {wr_bank_q, NLOG2'(bitrev(MAX_NLOG2'(ctr_i), NLOG2))};

    accept_d = accept_q;
    if (frame_start) accept_d = start_ok;
    if (wr_last)     accept_d = 1'b0;
    wr_bank_d  = wr_bank_q ^ wr_last;
    overflow_d = overflow_q | (frame_start & full_q[wr_bank_q]);

    // Set and clear target different banks, so both may land in one cycle.
    full_d = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;

    valid_d = valid_q;
    idx_d   = idx_q;
    if (!valid_q || ready_i) begin
      valid_d = rd_en;
      if (rd_en) idx_d = rd_addr_q;
    end
  end

  // Read FSM: the registered full flag makes the last written word visible.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rd_en     = 1'b0;
    rd_last   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = RD_DRAIN;
          rd_addr_d = '0;
        end
      end
      RD_DRAIN: begin
        rd_en = !valid_q || ready_i;
        if (rd_en) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == CTR_LAST) begin
            rd_last   = 1'b1;
            state_d   = RD_IDLE;
            rd_bank_d = !rd_bank_q;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      accept_q   <= 1'b0;
      overflow_q <= 1'b0;
      full_q     <= '0;
      state_q    <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      accept_q   <= accept_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
    end
  end

  ram_sdp #(
    .ADDR_W (NLOG2 + 1),
    .DEPTH  (2 * FFT_N),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk_3x_i (clk_3x_i),
    .rst_n    (rst_n),
    .we_i     (wr_en),
    .waddr_i  (wr_addr),
    .wdata_i  ({z_re_i, z_im_i}),
    .re_i     (rd_en),
    .raddr_i  ({rd_bank_q, rd_addr_q}),
    .rdata_o  (rd_word)
  );

  assign valid_o    = valid_q;
  assign idx_o      = idx_q;
  assign re_o       = rd_word[WORD_W-1 -: DATA_WIDTH];
  assign im_o       = rd_word[DATA_WIDTH-1:0];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder at FFT_N=8: frame-level reference model with a
// per-cycle output compare, plus directed literal checks per scenario.
module tb_fft_bitrev_reorder;

  localparam int DW     = 25;
  localparam int N      = 8;
  localparam int LG     = 3;
  localparam int BUDGET = 400;

  logic                 clk_3x_i = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 valid_i  = 1'b0;
  logic [LG-1:0]        ctr_i    = '0;
  logic signed [DW-1:0] z_re_i   = '0;
  logic signed [DW-1:0] z_im_i   = '0;
  logic                 ready_i  = 1'b1;
  logic                 valid_o;
  logic [LG-1:0]        idx_o;
  logic signed [DW-1:0] re_o;
  logic signed [DW-1:0] im_o;
  logic                 overflow_o;

  typedef struct {
    int idx;
    int re;
    int im;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  word_t nat[N];
  word_t last_w;
  word_t e_w;
  int    buffered  = 0;
  bit    accepting = 1'b0;
  bit    m_ovf     = 1'b0;
  bit    held      = 1'b0;
  int    n_out     = 0;
  bit    record_en = 1'b0;
  bit    vq[$];

  fft_bitrev_reorder #(
    .DATA_WIDTH (DW),
    .FFT_N      (N),
    .NLOG2      (LG)
  ) dut (
    .clk_3x_i   (clk_3x_i),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ctr_i      (ctr_i),
    .z_re_i     (z_re_i),
    .z_im_i     (z_im_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .idx_o      (idx_o),
    .re_o       (re_o),
    .im_o       (im_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_3x_i = ~clk_3x_i;

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) r |= ((v >> i) & 1) << (LG - 1 - i);
    return r;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: admit or drop whole frames (two buffers), place each
  // sample at its natural index, queue the frame in natural order on completion.
  task automatic model_input();
    if (ctr_i == 0) begin
      if (buffered == 2) begin
        m_ovf     = 1'b1;
        accepting = 1'b0;
      end else begin
        accepting = 1'b1;
      end
    end
    if (accepting) begin
      nat[rev(int'(ctr_i))] = '{rev(int'(ctr_i)), int'(z_re_i), int'(z_im_i)};
      if (ctr_i == LG'(N - 1)) begin
        for (int i = 0; i < N; i++) exp_q.push_back(nat[i]);
        buffered++;
        accepting = 1'b0;
      end
    end
  endtask

  // Outputs are stable at the falling edge; inputs change only 1ns after rising edges.
  always @(negedge clk_3x_i) begin
    if (valid_o === 1'b1) begin
      if (held) begin
        check("hold_idx", idx_o, last_w.idx);
        check("hold_re", re_o, last_w.re);
        check("hold_im", im_o, last_w.im);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx %0d re %0d with nothing expected", idx_o, re_o);
      end else begin
        e_w = exp_q.pop_front();
        check("out_idx", idx_o, e_w.idx);
        check("out_re", re_o, e_w.re);
        check("out_im", im_o, e_w.im);
        n_out++;
        if (e_w.idx == N - 1) buffered--;
      end
      last_w.idx = int'(idx_o);
      last_w.re  = int'(re_o);
      last_w.im  = int'(im_o);
    end
    check("overflow_o", overflow_o, m_ovf);
    if (record_en) vq.push_back(valid_o);
    held = rst_n && (valid_o === 1'b1) && !ready_i;
    if (!rst_n) begin
      exp_q.delete();
      buffered  = 0;
      accepting = 1'b0;
      m_ovf     = 1'b0;
    end else if (valid_i) begin
      model_input();
    end
  end

  task automatic tick();
    @(posedge clk_3x_i);
    #1;
  endtask

  // Frame f carries re = 8*f + bitrev(ctr), so natural bin i holds re = 8*f + i.
  task automatic drive(input int c, input int f);
    valid_i = 1'b1;
    ctr_i   = LG'(c);
    z_re_i  = DW'(8 * f + rev(c));
    z_im_i  = -z_re_i;
    tick();
  endtask

  task automatic send(input int f, input int first);
    for (int c = first; c < N; c++) drive(c, f);
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid_o !== 1'b0) && n < BUDGET) begin
      tick();
      n++;
    end
    check({name, "_drain_in_budget"}, n < BUDGET, 1);
    repeat (2) tick();
  endtask

  task automatic wait_idx(input string name, input int target);
    int n = 0;
    while (!(valid_o === 1'b1 && idx_o == LG'(target)) && n < BUDGET) begin
      tick();
      n++;
    end
    check(name, n < BUDGET, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int runs[$];
    int gaps[$];
    int cur;
    int zeros;
    bit started;

    // Reset state
    repeat (3) tick();
    check("rst_valid", valid_o, 0);
    check("rst_idx", idx_o, 0);
    check("rst_re", re_o, 0);
    check("rst_im", im_o, 0);
    check("rst_ovf", overflow_o, 0);
    rst_n = 1'b1;
    tick();

    // Ordering and latency: bin i comes out with re = i, im = -i
    base = n_out;
    send(0, 0);
    check("a_lat_edge0_valid", valid_o, 0);
    tick();
    check("a_lat_edge1_valid", valid_o, 0);
    tick();
    check("a_lat_edge2_valid", valid_o, 1);
    check("a_first_idx", idx_o, 0);
    check("a_first_re", re_o, 0);
    check("a_first_im", im_o, 0);
    tick();
    check("a_second_idx", idx_o, 1);
    check("a_second_im", im_o, -1);
    wait_drain("a");
    check("a_count", n_out - base, 8);

    // Backpressure: hold bin 3 for five stalled edges
    base = n_out;
    send(0, 0);
    wait_idx("b_reach_idx3", 3);
    ready_i = 1'b0;
    repeat (5) begin
      tick();
      check("b_stall_valid", valid_o, 1);
      check("b_stall_idx", idx_o, 3);
      check("b_stall_re", re_o, 3);
    end
    ready_i = 1'b1;
    tick();
    check("b_resume_idx", idx_o, 4);
    wait_drain("b");
    check("b_count", n_out - base, 8);

    // Overflow: three back-to-back frames with output stalled
    base    = n_out;
    ready_i = 1'b0;
    send(1, 0);
    send(2, 0);
    check("c_ovf_before_f3", overflow_o, 0);
    drive(0, 3);
    check("c_ovf_at_f3", overflow_o, 1);
    for (int c = 1; c < N; c++) drive(c, 3);
    valid_i = 1'b0;
    check("c_stalled_idx", idx_o, 0);
    check("c_stalled_re", re_o, 8);
    check("c_stalled_im", im_o, -8);
    ready_i = 1'b1;
    wait_drain("c");
    check("c_count", n_out - base, 16);
    check("c_ovf_sticky", overflow_o, 1);

    // Mid-drain reset: nothing further from that frame, overflow cleared
    send(4, 0);
    wait_idx("e_reach_idx4", 4);
    check("e_pre_reset_re", re_o, 36);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("e_post_valid", valid_o, 0);
    check("e_post_ovf", overflow_o, 0);
    check("e_post_idx", idx_o, 0);
    repeat (12) tick();
    check("e_quiet_valid", valid_o, 0);
    base = n_out;
    send(5, 0);
    tick();
    tick();
    check("e_next_first_idx", idx_o, 0);
    check("e_next_first_re", re_o, 40);
    wait_drain("e");
    check("e_count", n_out - base, 8);

    // Resync: a frame tail arriving first is ignored
    do_reset();
    base = n_out;
    send(6, 5);
    repeat (6) tick();
    check("d_partial_no_valid", valid_o, 0);
    send(7, 0);
    wait_drain("d");
    check("d_count", n_out - base, 8);

    // Streaming: input spaced one idle cycle per frame to match the drain rate
    base      = n_out;
    record_en = 1'b1;
    for (int f = 8; f < 12; f++) begin
      send(f, 0);
      tick();
    end
    wait_drain("f");
    record_en = 1'b0;
    check("f_count", n_out - base, 32);
    check("f_ovf", overflow_o, 0);
    cur     = 0;
    zeros   = 0;
    started = 1'b0;
    foreach (vq[k]) begin
      if (vq[k]) begin
        if (started && zeros > 0) gaps.push_back(zeros);
        zeros   = 0;
        cur++;
        started = 1'b1;
      end else begin
        if (cur > 0) begin
          runs.push_back(cur);
          cur = 0;
        end
        if (started) zeros++;
      end
    end
    if (cur > 0) runs.push_back(cur);
    check("f_runs", runs.size(), 4);
    check("f_gaps", gaps.size(), 3);
    foreach (runs[k]) check("f_run_len", runs[k], 8);
    foreach (gaps[k]) check("f_gap_len", gaps[k], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
